// File: rtl/spi_flash_reader.sv
// ---------------------------------------------------------------------------
// spi_flash_reader
//
// SPI flash read engine (SPI mode 0). A start request is accepted while idle;
// the engine then lowers chip select, shifts out the read command and a
// 24-bit byte address MSB first, optionally clocks 8 dummy cycles
// (FAST_READ), shifts in DATA_WIDTH bits from MISO and presents them on
// oData together with a single-cycle oDataValid pulse. Chip select is then
// held high for a recovery period before the next request can be accepted.
//
// Parameters
//   DATA_WIDTH  bits read per transaction (multiple of 8, 8..64)
//   CLK_DIV     system clocks per SCK half-period (>= 1)
//   FAST_READ   0: command 8'h03, no dummy; 1: command 8'h0B + 8 dummy SCKs
//
// Ports
//   Clock       system clock, all logic on its rising edge
//   Reset       synchronous, active-high
//   iStart      request; accepted when iStart=1 and oBusy=0
//   iAddress    flash byte address, captured on acceptance
//   iSPIIn      flash MISO
//   oBusy       high from the cycle after acceptance to the end of recovery
//   oDataValid  one-cycle pulse, oData holds a new word
//   oData       last word read, MSB = first bit received
//   oSPIClock   SCK, idle low
//   oSPICs      chip select, active-low
//   oSPIOut     MOSI
// ---------------------------------------------------------------------------
module spi_flash_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int CLK_DIV    = 2,
   parameter int FAST_READ  = 0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iStart,
   input  logic [23:0]           iAddress,
   input  logic                  iSPIIn,
   output logic                  oBusy,
   output logic                  oDataValid,
   output logic [DATA_WIDTH-1:0] oData,
   output logic                  oSPIClock,
   output logic                  oSPICs,
   output logic                  oSPIOut
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CMD     = 3'd1;
   localparam logic [2:0] S_DUMMY   = 3'd2;
   localparam logic [2:0] S_READ    = 3'd3;
   localparam logic [2:0] S_RECOVER = 3'd4;

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int REC_W = $clog2(2 * CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [REC_W-1:0] REC_LAST   = REC_W'(2 * CLK_DIV - 1);
   localparam logic [7:0]       CMD_BYTE   = (FAST_READ != 0) ? 8'h0B : 8'h03;
   localparam logic [6:0]       CMD_LAST   = 7'd31;
   localparam logic [6:0]       DUMMY_LAST = 7'd7;
   localparam logic [6:0]       READ_LAST  = 7'(DATA_WIDTH - 1);

   logic [2:0]            state;
   logic [DIV_W-1:0]      div_cnt;
   logic [REC_W-1:0]      rec_cnt;
   logic [6:0]            bit_cnt;
   // Remaining command/address bits; bit 31 of the frame goes straight
   // to oSPIOut at acceptance, so only 31 bits are kept here.
   logic [30:0]           shift_out;
   logic [DATA_WIDTH-1:0] shift_in;

   logic div_wrap;
   logic sck_rise;
   logic sck_fall;

   // The divider wrap is the only point where SCK toggles; the current SCK
   // level tells whether that toggle is a rising or falling edge.
   assign div_wrap = (div_cnt == DIV_LAST);
   assign sck_rise = div_wrap && !oSPIClock;
   assign sck_fall = div_wrap &&  oSPIClock;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         rec_cnt    <= '0;
         bit_cnt    <= '0;
         shift_out  <= '0;
         shift_in   <= '0;
         oBusy      <= 1'b0;
         oDataValid <= 1'b0;
         oData      <= '0;
         oSPIClock  <= 1'b0;
         oSPICs     <= 1'b1;
         oSPIOut    <= 1'b0;
      end else begin
         oDataValid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (iStart) begin
                  state     <= S_CMD;
                  oBusy     <= 1'b1;
                  oSPICs    <= 1'b0;
                  oSPIClock <= 1'b0;
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
                  oSPIOut   <= CMD_BYTE[7];
                  shift_out <= {CMD_BYTE[6:0], iAddress};
               end
            end

            S_CMD, S_DUMMY, S_READ: begin
               if (!div_wrap) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt   <= '0;
                  oSPIClock <= ~oSPIClock;

                  if (sck_rise && (state == S_READ)) begin
                     shift_in <= {shift_in[DATA_WIDTH-2:0], iSPIIn};
                  end

                  // Every bit ends on an SCK falling edge; MOSI and phase
                  // changes happen only here, so nothing moves while SCK
                  // is high.
                  if (sck_fall) begin
                     bit_cnt <= bit_cnt + 7'd1;
                     case (state)
                        S_CMD: begin
                           if (bit_cnt == CMD_LAST) begin
                              bit_cnt <= '0;
                              oSPIOut <= 1'b0;
                              state   <= (FAST_READ != 0) ? S_DUMMY : S_READ;
                           end else begin
                              oSPIOut   <= shift_out[30];
                              shift_out <= {shift_out[29:0], 1'b0};
                           end
                        end
                        S_DUMMY: begin
                           if (bit_cnt == DUMMY_LAST) begin
                              bit_cnt <= '0;
                              state   <= S_READ;
                           end
                        end
                        S_READ: begin
                           // The last data bit was captured on the preceding
                           // rising edge, so shift_in is complete here.
                           if (bit_cnt == READ_LAST) begin
                              oSPICs     <= 1'b1;
                              oData      <= shift_in;
                              oDataValid <= 1'b1;
                              rec_cnt    <= '0;
                              state      <= S_RECOVER;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end

            S_RECOVER: begin
               if (rec_cnt == REC_LAST) begin
                  state <= S_IDLE;
                  oBusy <= 1'b0;
               end else begin
                  rec_cnt <= rec_cnt + 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Parametrised SPI flash read engine: on a start request it asserts chip select, shifts out a read command and a 24-bit address, optionally clocks dummy cycles, then shifts in a configurable number of data bits and presents them with a one-cycle valid strobe. It replaces the fixed 16-bit, enable-driven read path with a start/busy/valid handshake, a programmable SPI clock divider, real MISO capture, and optional FAST_READ mode. It sits between the system-side consumer (ROM/asset loader) and the board SPI flash pins.

## Interface
- DATA_WIDTH, 16, bits read per transaction; multiple of 8, range 8..64
- CLK_DIV, 2, system clocks per SPI half-period; at least 1
- FAST_READ, 0, 0: command 8'h03 with no dummy; 1: command 8'h0B followed by 8 dummy SCK cycles
- Clock  in  1  system clock; all logic on its rising edge
- Reset  in  1  synchronous, active-high
- iStart  in  1  request; accepted on any edge where iStart=1 and oBusy=0
- iAddress  in  24  flash byte address; captured on acceptance
- iSPIIn  in  1  flash MISO
- oBusy  out  1  high from the cycle after acceptance until the end of CS-high recovery
- oDataValid  out  1  one-cycle pulse; oData is new
- oData  out  DATA_WIDTH  last word read, MSB = first bit received; held until the next valid
- oSPIClock  out  1  SCK, SPI mode 0 (idle low)
- oSPICs  out  1  chip select, active-low
- oSPIOut  out  1  MOSI

## Operation
- Reset values: oBusy=0, oDataValid=0, oData=0, oSPIClock=0, oSPICs=1, oSPIOut=0.
- States: IDLE -> CMD (32 bits: command byte then iAddress, MSB first) -> DUMMY (8 bits, only if FAST_READ=1, MOSI=0) -> READ (DATA_WIDTH bits, MOSI=0) -> RECOVER (2*CLK_DIV cycles, CS high) -> IDLE.
- N = 32 + 8*FAST_READ + DATA_WIDTH bits per transaction; each bit takes 2*CLK_DIV cycles.
- A divider counter runs 0..CLK_DIV-1 while CS is low. SCK toggles on each wrap.
- MOSI changes only while SCK is low: the first bit is driven with CS assertion, and each subsequent bit is driven on the SCK falling edge.
- MISO is sampled in READ on each cycle where SCK goes from 0 to 1. It is shifted into an internal register, not into oData directly.
- On the final SCK falling edge, in the same cycle:
  - CS deasserts.
  - oData loads from the shift register.
  - oDataValid pulses.
- Boundary conditions:
  - iStart while oBusy=1 is ignored and not queued.
  - iAddress changes after acceptance have no effect.
  - Reset has priority over iStart in the same cycle.
  - Reset mid-transaction forces all outputs to their reset values on the next cycle. No valid pulse is produced and oData clears.
  - iStart held high continuously issues back-to-back reads, each separated by the recovery period.

## Timing
- Acceptance edge E. At E+1: oSPICs=0, oBusy=1, oSPIOut=command bit 7, SCK=0.
- Bit k (0-based) rising edge at cycle E+1+CLK_DIV*(2k+1). Its falling edge is at E+1+2*CLK_DIV*(k+1).
- At E+1+2N*CLK_DIV: oDataValid=1, oSPICs=1, SCK=0. The default latency is 193 cycles (N=48, CLK_DIV=2).
- oBusy falls at E+1+2N*CLK_DIV+2*CLK_DIV (E+197 default). The next acceptance is possible at that cycle's edge.
- Minimum CS-high time between transactions is 2*CLK_DIV+1 cycles.
- SCK never glitches. CS never changes while SCK is high.

## Test plan
- Defaults, address 0x012345, flash model returns 0xA5C3 -> MOSI carries 0x03012345, oData=16'hA5C3, oDataValid pulse exactly 193 cycles after acceptance, single cycle wide.
- FAST_READ=1, DATA_WIDTH=32, address 0xFFFFFF, model returns 0xDEADBEEF -> MOSI 0x0BFFFFFF then 8 zero dummy bits, oData=32'hDEADBEEF, latency 1+2*72*2=289.
- CLK_DIV=1 -> SCK period 2 cycles, latency 97, MISO sampled only on rising SCK.
- iStart pulsed again at E+50 with a different address -> ignored; the one transaction returns data for the original address.
- Reset asserted at E+60 -> next cycle CS=1, SCK=0, busy=0, oData=0, no valid pulse. A new start then completes normally.
- iStart held high for two reads -> CS high for exactly 5 cycles between them, two valid pulses 197 cycles apart.
